// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular round-robin arbiter onto the MAC tx AXI-Stream port.
// Define TX_ARB_IFG_EN to force IFG_CYCLES idle cycles after every frame.
module tx_frame_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 12,
    parameter int IFG_CYCLES = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy,
    output logic [LEN_W-1:0]          frame_len,
    output logic                      frame_len_vld,
    output logic [15:0]               frame_cnt
);
    localparam int PTR_W = $clog2(NUM_SRC);
`ifdef TX_ARB_IFG_EN
    localparam int IFG_W = $clog2(IFG_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, SEND, IFG} state_t;
    logic [IFG_W-1:0] ifg_cnt;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif
    state_t           state;
    logic [PTR_W-1:0] rr_ptr, gidx, sel;
    logic [PTR_W:0]   cand;
    logic [LEN_W-1:0] len_cnt, len_inc;
    logic             send, xfer;

    assign send     = state == SEND;
    assign m_tvalid = send & s_tvalid[gidx];
    assign m_tlast  = send & s_tlast[gidx];
    assign m_tdata  = send ? s_tdata[gidx*DATA_W +: DATA_W] : '0;
    assign s_tready = send ? NUM_SRC'(m_tready) << gidx : '0;
    assign busy     = state != IDLE;
    assign xfer     = m_tvalid & m_tready;
    assign len_inc  = &len_cnt ? len_cnt : len_cnt + 1'b1;

    // Walk candidates from the far end so the one closest to rr_ptr wins.
    always_comb begin
        sel  = rr_ptr;
        cand = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            cand = cand >= (PTR_W+1)'(NUM_SRC) ? cand - (PTR_W+1)'(NUM_SRC) : cand;
            sel  = s_tvalid[cand[PTR_W-1:0]] ? cand[PTR_W-1:0] : sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            gidx          <= '0;
            len_cnt       <= '0;
            frame_len     <= '0;
            frame_len_vld <= 1'b0;
            frame_cnt     <= '0;
`ifdef TX_ARB_IFG_EN
            ifg_cnt       <= '0;
`endif
        end else begin
            frame_len_vld <= 1'b0;
            case (state)
                IDLE: if (|s_tvalid) begin
                    grant <= NUM_SRC'(1) << sel;
                    gidx  <= sel;
                    state <= SEND;
                end
                SEND: if (xfer) begin
                    len_cnt <= m_tlast ? '0 : len_inc;
                    if (m_tlast) begin
                        frame_len     <= len_inc;
                        frame_len_vld <= 1'b1;
                        frame_cnt     <= frame_cnt + 1'b1;
                        rr_ptr        <= gidx == PTR_W'(NUM_SRC - 1) ? '0 : gidx + 1'b1;
                        grant         <= '0;
`ifdef TX_ARB_IFG_EN
                        ifg_cnt       <= IFG_W'(IFG_CYCLES);
                        state         <= IFG;
`else
                        state         <= IDLE;
`endif
                    end
                end
`ifdef TX_ARB_IFG_EN
                IFG: begin
                    ifg_cnt <= ifg_cnt <= 1 ? '0 : ifg_cnt - 1'b1;
                    state   <= ifg_cnt <= 1 ? IDLE : IFG;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized frame traffic checked against a frame-level round-robin model.
module tb_tx_frame_arbiter;
    localparam int NS  = 2;
    localparam int DW  = 8;
    localparam int LW  = 12;
    localparam int IFG = 12;
`ifdef TX_ARB_IFG_EN
    localparam int IFG_EXP = IFG == 0 ? 1 : IFG;
`else
    localparam int IFG_EXP = 0;
`endif
    localparam int EXP_GAP = IFG_EXP + 1;

    logic             clk = 0, rst = 0;
    logic [NS*DW-1:0] s_tdata = '0;
    logic [NS-1:0]    s_tvalid = '0, s_tlast = '0, s_tready, grant;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid, m_tlast, m_tready = 0, busy, frame_len_vld;
    logic [LW-1:0]    frame_len;
    logic [15:0]      frame_cnt;

    tx_frame_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .LEN_W(LW), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .grant(grant), .busy(busy), .frame_len(frame_len),
        .frame_len_vld(frame_len_vld), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          lens[NS][$];
    int          drv_beat[NS], fid[NS];
    int          m_owner, m_ptr, gap, post, idle_req, xfers, pend_len, rdy_mode;
    logic [15:0] m_cnt;
    bit          pend_vld, after_frame, gaps;
    int          n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] pat(input int s, input int f, input int b);
        return DW'(s * 101 + f * 37 + b * 13 + b / 256);
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NS; i++) if (lens[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; s_tvalid = '0; s_tlast = '0;
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_s_tready", 32'(s_tready), 0);
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tlast", 32'(m_tlast), 0);
        check("rst_m_tdata", 32'(m_tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_len", 32'(frame_len), 0);
        check("rst_len_vld", 32'(frame_len_vld), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        for (int i = 0; i < NS; i++) begin
            lens[i].delete(); drv_beat[i] = 0;
        end
        m_owner = -1; m_ptr = 0; m_cnt = '0; pend_vld = 0; post = 0;
        gap = 0; idle_req = 0; after_frame = 0;
    endtask

    task automatic step();
        int e, g, j;
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (lens[i].size() > 0) begin
                s_tvalid[i] = (drv_beat[i] == 0 || !gaps) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_tdata[i*DW +: DW] = pat(i, fid[i], drv_beat[i]);
                s_tlast[i] = drv_beat[i] == lens[i][0] - 1;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i*DW +: DW] = DW'($urandom);
                s_tlast[i] = 1'($urandom_range(0, 1));
            end
        end
        m_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_tready : ($urandom_range(0, 2) != 0);
        #1;
        check("len_vld", 32'(frame_len_vld), 32'(pend_vld));
        if (pend_vld) check("frame_len", 32'(frame_len), 32'(pend_len));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        pend_vld = 0;
        if (m_owner < 0 && grant != 0) begin
            e = -1;
            for (int k = 0; k < NS; k++) begin
                j = (m_ptr + k) % NS;
                if (e < 0 && lens[j].size() > 0) e = j;
            end
            check("arb_grant", 32'(grant), e < 0 ? 0 : 32'(1 << e));
            check("arb_latency", 32'(idle_req), 1);
            if (after_frame && rdy_mode == 0) check("frame_gap", 32'(gap), 32'(EXP_GAP));
            idle_req = 0;
            m_owner = e;
        end
        if (m_owner >= 0) begin
            g = m_owner;
            check("grant", 32'(grant), 32'(1 << g));
            check("busy_send", 32'(busy), 1);
            check("s_tready", 32'(s_tready), m_tready ? 32'(1 << g) : 0);
            check("m_tvalid", 32'(m_tvalid), 32'(s_tvalid[g]));
            if (m_tvalid) begin
                check("m_tdata", 32'(m_tdata), 32'(pat(g, fid[g], drv_beat[g])));
                check("m_tlast", 32'(m_tlast), 32'(drv_beat[g] == lens[g][0] - 1));
            end
            if (s_tvalid[g] && m_tready) begin
                xfers++;
                if (drv_beat[g] == lens[g][0] - 1) begin
                    pend_len = lens[g][0] > 4095 ? 4095 : lens[g][0];
                    pend_vld = 1;
                    m_cnt = m_cnt + 16'd1;
                    m_ptr = (g + 1) % NS;
                    m_owner = -1;
                    void'(lens[g].pop_front());
                    drv_beat[g] = 0;
                    fid[g]++;
                    gap = 0;
                    post = IFG_EXP;
                    after_frame = pending();
                end else drv_beat[g]++;
            end
        end else begin
            check("idle_grant", 32'(grant), 0);
            check("idle_m_tvalid", 32'(m_tvalid), 0);
            check("idle_s_tready", 32'(s_tready), 0);
            check("idle_busy", 32'(busy), 32'(post > 0));
            if (post > 0) post--;
            else if (|s_tvalid) idle_req++;
            gap++;
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((pending() || m_owner >= 0) && n < budget) begin
            step();
            n++;
        end
        check("run_timeout", 32'(pending() || m_owner >= 0), 0);
        for (int i = 0; i < EXP_GAP + 3; i++) step();
    endtask

    task automatic run_xfers(input int target, input int budget);
        int n = 0;
        while (xfers < target && n < budget) begin
            step();
            n++;
        end
        check("xfer_timeout", 32'(xfers >= target), 1);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) fid[i] = 0;
        xfers = 0; gaps = 0; rdy_mode = 0;
        do_reset();
        lens[0].push_back(64);
        run(200);
        check("t1_frame_cnt", 32'(frame_cnt), 1);
        check("t1_frame_len", 32'(frame_len), 64);

        do_reset();
        for (int f = 0; f < 3; f++) begin
            lens[0].push_back(10);
            lens[1].push_back(10);
        end
        run(400);
        check("t2_frame_cnt", 32'(frame_cnt), 6);

        rdy_mode = 1;
        lens[1].push_back(20);
        lens[0].push_back(20);
        run(200);

        gaps = 1; rdy_mode = 2;
        for (int f = 0; f < 8; f++) begin
            lens[0].push_back($urandom_range(1, 40));
            lens[1].push_back($urandom_range(1, 40));
        end
        run(2000);

        gaps = 0; rdy_mode = 0;
        lens[1].push_back(1);
        lens[1].push_back(1);
        run(100);
        check("ifg_frame_len", 32'(frame_len), 1);

        lens[0].push_back(3);
        run(100);
        lens[1].push_back(30);
        xfers = 0;
        run_xfers(5, 100);
        do_reset();
        lens[0].push_back(4);
        lens[1].push_back(4);
        run(100);
        check("post_rst_cnt", 32'(frame_cnt), 2);

        lens[0].push_back(2048);
        run(2200);
        check("len_2048", 32'(frame_len), 2048);
        lens[1].push_back(4100);
        run(4300);
        check("len_sat", 32'(frame_len), 4095);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
